// File: rtl/panel_ctrl_if.sv
// panel_ctrl_if: panel-to-memory request/acknowledge port
interface panel_ctrl_if #(
   parameter int AW = 12
) ();
   logic          MEM_REQ;
   logic          MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [AW-1:0] MEM_WDATA;
   logic [AW-1:0] MEM_RDATA;
   logic          MEM_ACK;

   modport master (
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      input  MEM_RDATA, MEM_ACK
   );

   modport slave (
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      output MEM_RDATA, MEM_ACK
   );
endinterface

// File: rtl/panel_ctrl.sv
// panel_ctrl: console switch debounce, sequencer pulses and panel memory cycles
module panel_ctrl #(
   parameter int DEBOUNCE = 16,
   parameter int TIMEOUT  = 8,
   parameter int AW       = 12
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          SW_START,
   input  logic          SW_HALT,
   input  logic          SW_STEPM,
   input  logic          SW_STEPI,
   input  logic          SW_LA,
   input  logic          SW_DEP,
   input  logic          SW_EXAM,
   input  logic [AW-1:0] SR,
   input  logic          CPU_IDLE,
   output logic          RUN,
   output logic          HALT,
   output logic          STEPM,
   output logic          STEPI,
   output logic [AW-1:0] DISP_MA,
   output logic [AW-1:0] DISP_MB,
   output logic          BUSY,
   output logic          MEM_ERR,
   panel_ctrl_if.master  mem
);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t        state;
   logic [6:0]    raw;
   logic [6:0]    lvl;
   logic [6:0]    press;
   logic [6:0]    sel;
   logic [CW-1:0] dcnt [7];
   logic [TW-1:0] tcnt;
   logic [AW-1:0] pa;
   logic          idle_ok;

   // bit order is press priority: HALT, START, STEPI, STEPM, LA, DEP, EXAM
   assign raw     = {SW_EXAM, SW_DEP, SW_LA, SW_STEPM, SW_STEPI, SW_START, SW_HALT};
   assign sel     = press & (~press + 7'd1);
   assign idle_ok = CPU_IDLE && state == IDLE;
   assign DISP_MA = pa;
   assign mem.MEM_ADDR = pa;
   assign BUSY    = state != IDLE;

   // debounce each switch; a rising flip of the settled level is one press
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lvl   <= '0;
         press <= '0;
         for (int i = 0; i < 7; i++) dcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            press[i] <= 1'b0;
            if (raw[i] != lvl[i]) begin
               if (dcnt[i] == CW'(DEBOUNCE - 1)) begin
                  lvl[i]   <= raw[i];
                  dcnt[i]  <= '0;
                  press[i] <= raw[i];
               end else begin
                  dcnt[i] <= dcnt[i] + CW'(1);
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   // panel FSM: sequencer pulses, load address, deposit/examine with timeout
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         RUN           <= 1'b0;
         HALT          <= 1'b0;
         STEPM         <= 1'b0;
         STEPI         <= 1'b0;
         pa            <= '0;
         DISP_MB       <= '0;
         MEM_ERR       <= 1'b0;
         tcnt          <= '0;
         mem.MEM_REQ   <= 1'b0;
         mem.MEM_WE    <= 1'b0;
         mem.MEM_WDATA <= '0;
      end else begin
         HALT  <= sel[0];
         RUN   <= sel[1] && idle_ok;
         STEPI <= sel[2] && idle_ok;
         STEPM <= sel[3] && idle_ok;
         case (state)
            IDLE: begin
               if (CPU_IDLE) begin
                  if (sel[4]) begin
                     pa <= SR;
                  end else if (sel[5] || sel[6]) begin
                     state         <= sel[5] ? WRITE : READ;
                     mem.MEM_REQ   <= 1'b1;
                     mem.MEM_WE    <= sel[5];
                     mem.MEM_WDATA <= sel[5] ? SR : mem.MEM_WDATA;
                     MEM_ERR       <= 1'b0;
                     tcnt          <= TW'(1);
                  end
               end
            end
            WRITE, READ: begin
               if (mem.MEM_ACK) begin
                  DISP_MB     <= state == WRITE ? mem.MEM_WDATA : mem.MEM_RDATA;
                  pa          <= pa + AW'(1);
                  mem.MEM_REQ <= 1'b0;
                  mem.MEM_WE  <= 1'b0;
                  state       <= IDLE;
               end else if (tcnt == TW'(TIMEOUT)) begin
                  MEM_ERR     <= 1'b1;
                  mem.MEM_REQ <= 1'b0;
                  mem.MEM_WE  <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_panel_ctrl.sv
// tb_panel_ctrl: scoreboard bench for the front-panel controller
module tb_panel_ctrl;
   localparam int AW = 12;
   localparam int DB = 16;
   localparam int TO = 8;
   localparam int HALT_I = 0, START_I = 1, STEPI_I = 2, STEPM_I = 3, LA_I = 4, DEP_I = 5, EXAM_I = 6;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [AW-1:0] wdata;
   } txn_t;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          CPU_IDLE = 1'b1;
   logic [6:0]    sw = '0;
   logic [AW-1:0] SR = '0;
   logic          RUN, HALT, STEPM, STEPI, BUSY, MEM_ERR;
   logic [AW-1:0] DISP_MA, DISP_MB;
   logic [AW-1:0] pa_m = '0;
   txn_t          exp_q[$];
   int            n_cmp = 0, n_bad = 0;
   int            run_n = 0, halt_n = 0, stepm_n = 0, stepi_n = 0;

   panel_ctrl_if #(.AW(AW)) mem ();

   panel_ctrl #(.DEBOUNCE(DB), .TIMEOUT(TO), .AW(AW)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .SW_START(sw[START_I]), .SW_HALT(sw[HALT_I]), .SW_STEPM(sw[STEPM_I]),
      .SW_STEPI(sw[STEPI_I]), .SW_LA(sw[LA_I]), .SW_DEP(sw[DEP_I]), .SW_EXAM(sw[EXAM_I]),
      .SR(SR), .CPU_IDLE(CPU_IDLE),
      .RUN(RUN), .HALT(HALT), .STEPM(STEPM), .STEPI(STEPI),
      .DISP_MA(DISP_MA), .DISP_MB(DISP_MB), .BUSY(BUSY), .MEM_ERR(MEM_ERR),
      .mem(mem)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RUN === 1'b1) run_n++;
      if (HALT === 1'b1) halt_n++;
      if (STEPM === 1'b1) stepm_n++;
      if (STEPI === 1'b1) stepi_n++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_la(input logic [AW-1:0] v);
      SR = v;
      sw[LA_I] = 1'b1;
      tick(DB + 3);
      sw[LA_I] = 1'b0;
      tick(DB + 3);
      pa_m = v;
   endtask

   // drive DEP/EXAM, check the request against the scoreboard, ack on cycle ack_at (0 = never)
   task automatic mem_op(input int idx, input logic [AW-1:0] sr_v, input int ack_at,
                         input logic [AW-1:0] rd, input int exp_cyc, input string nm);
      txn_t e;
      int   w, cyc, we_bad;
      exp_q.push_back('{idx == DEP_I, pa_m, sr_v});
      SR = sr_v;
      sw[idx] = 1'b1;
      w = 0;
      while (mem.MEM_REQ !== 1'b1 && w < 40) begin
         tick(1);
         w++;
      end
      n_cmp++;
      if (mem.MEM_REQ !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_req: MEM_REQ never rose within 40 cycles", nm);
         void'(exp_q.pop_front());
         sw[idx] = 1'b0;
         tick(DB + 3);
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (mem.MEM_ADDR !== e.addr || (e.we && mem.MEM_WDATA !== e.wdata) || MEM_ERR !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_entry: addr=%o wdata=%o err=%b, required addr=%o wdata=%o err=0",
                  nm, mem.MEM_ADDR, mem.MEM_WDATA, MEM_ERR, e.addr, e.wdata);
      end
      cyc = 0;
      we_bad = 0;
      while (mem.MEM_REQ === 1'b1 && cyc < 30) begin
         cyc++;
         if (mem.MEM_WE !== e.we) we_bad++;
         if (cyc == ack_at) begin
            mem.MEM_RDATA = rd;
            mem.MEM_ACK = 1'b1;
         end
         tick(1);
         mem.MEM_ACK = 1'b0;
      end
      n_cmp++;
      if (cyc != exp_cyc || we_bad != 0) begin
         n_bad++;
         $display("FAIL %s_hold: req cycles=%0d we errors=%0d, required %0d and 0", nm, cyc, we_bad, exp_cyc);
      end
      n_cmp++;
      if (BUSY !== 1'b0 || mem.MEM_REQ !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done: busy=%b req=%b, required 0 0", nm, BUSY, mem.MEM_REQ);
      end
      if (ack_at > 0 && ack_at <= exp_cyc) pa_m = pa_m + AW'(1);
      sw[idx] = 1'b0;
      tick(DB + 3);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      mem.MEM_ACK = 1'b0;
      mem.MEM_RDATA = '0;
      tick(2);
      n_cmp++;
      if ({RUN, HALT, STEPM, STEPI, BUSY, MEM_ERR, mem.MEM_REQ, mem.MEM_WE, mem.MEM_ADDR,
           mem.MEM_WDATA, DISP_MA, DISP_MB} !== '0) begin
         n_bad++;
         $display("FAIL reset: outputs not all zero (ma=%o mb=%o req=%b busy=%b)", DISP_MA, DISP_MB, mem.MEM_REQ, BUSY);
      end
      RESET_N = 1'b1;
      tick(2);
   endtask

   task automatic test_load_addr();
      SR = 12'o1234;
      sw[LA_I] = 1'b1;
      tick(DB);
      n_cmp++;
      if (DISP_MA !== 12'o0000) begin
         n_bad++;
         $display("FAIL la_early: ma=%o, required 0000", DISP_MA);
      end
      tick(1);
      n_cmp++;
      if (DISP_MA !== 12'o1234) begin
         n_bad++;
         $display("FAIL la_load: ma=%o, required 1234", DISP_MA);
      end
      SR = 12'o5555;
      tick(10);
      n_cmp++;
      if (DISP_MA !== 12'o1234 || mem.MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL la_hold: ma=%o req=%b busy=%b, required 1234 0 0", DISP_MA, mem.MEM_REQ, BUSY);
      end
      sw[LA_I] = 1'b0;
      tick(DB + 3);
      pa_m = 12'o1234;
   endtask

   task automatic test_deposit_wrap();
      do_la(12'o7777);
      mem_op(DEP_I, 12'o0055, 3, 12'o0000, 3, "dep_wrap");
      n_cmp++;
      if (DISP_MB !== 12'o0055 || DISP_MA !== 12'o0000) begin
         n_bad++;
         $display("FAIL dep_wrap_disp: mb=%o ma=%o, required 0055 0000", DISP_MB, DISP_MA);
      end
   endtask

   task automatic test_examine();
      do_la(12'o0200);
      mem_op(EXAM_I, 12'o0000, 1, 12'o4321, 1, "exam");
      n_cmp++;
      if (DISP_MB !== 12'o4321 || DISP_MA !== 12'o0201) begin
         n_bad++;
         $display("FAIL exam_disp: mb=%o ma=%o, required 4321 0201", DISP_MB, DISP_MA);
      end
      mem.MEM_RDATA = 12'o7070;
      mem.MEM_ACK = 1'b1;
      tick(1);
      mem.MEM_ACK = 1'b0;
      tick(1);
      n_cmp++;
      if (DISP_MB !== 12'o4321 || DISP_MA !== 12'o0201 || BUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_ack: mb=%o ma=%o busy=%b, required 4321 0201 0", DISP_MB, DISP_MA, BUSY);
      end
   endtask

   task automatic test_timeout();
      mem_op(DEP_I, 12'o3333, 0, 12'o0000, TO, "dep_timeout");
      n_cmp++;
      if (MEM_ERR !== 1'b1 || DISP_MA !== 12'o0201 || DISP_MB !== 12'o4321) begin
         n_bad++;
         $display("FAIL timeout_state: err=%b ma=%o mb=%o, required 1 0201 4321", MEM_ERR, DISP_MA, DISP_MB);
      end
      mem_op(EXAM_I, 12'o0000, 2, 12'o0707, 2, "exam_after_err");
      n_cmp++;
      if (MEM_ERR !== 1'b0 || DISP_MB !== 12'o0707 || DISP_MA !== 12'o0202) begin
         n_bad++;
         $display("FAIL err_clear: err=%b mb=%o ma=%o, required 0 0707 0202", MEM_ERR, DISP_MB, DISP_MA);
      end
   endtask

   task automatic test_pulses();
      int r0, h0, m0, i0;
      r0 = run_n; h0 = halt_n; m0 = stepm_n; i0 = stepi_n;
      sw[START_I] = 1'b1;
      tick(5);
      sw[START_I] = 1'b0;
      tick(DB + 5);
      n_cmp++;
      if (run_n != r0) begin
         n_bad++;
         $display("FAIL start_glitch: run pulses=%0d, required 0", run_n - r0);
      end
      CPU_IDLE = 1'b0;
      sw[START_I] = 1'b1;
      tick(DB + 3);
      sw[START_I] = 1'b0;
      tick(DB + 3);
      CPU_IDLE = 1'b1;
      n_cmp++;
      if (run_n != r0) begin
         n_bad++;
         $display("FAIL start_not_idle: run pulses=%0d, required 0", run_n - r0);
      end
      sw[START_I] = 1'b1;
      tick(DB + 3);
      sw[START_I] = 1'b0;
      tick(DB + 3);
      n_cmp++;
      if (run_n != r0 + 1) begin
         n_bad++;
         $display("FAIL start_clean: run pulses=%0d, required 1", run_n - r0);
      end
      sw[START_I] = 1'b1;
      sw[HALT_I] = 1'b1;
      tick(DB + 3);
      sw[START_I] = 1'b0;
      sw[HALT_I] = 1'b0;
      tick(DB + 3);
      n_cmp++;
      if (halt_n != h0 + 1 || run_n != r0 + 1) begin
         n_bad++;
         $display("FAIL halt_start: halt cycles=%0d run pulses=%0d, required 1 0", halt_n - h0, run_n - r0 - 1);
      end
      sw[STEPI_I] = 1'b1;
      tick(DB + 3);
      sw[STEPI_I] = 1'b0;
      tick(DB + 3);
      sw[STEPM_I] = 1'b1;
      tick(DB + 3);
      sw[STEPM_I] = 1'b0;
      tick(DB + 3);
      n_cmp++;
      if (stepi_n != i0 + 1 || stepm_n != m0 + 1) begin
         n_bad++;
         $display("FAIL steps: stepi=%0d stepm=%0d, required 1 1", stepi_n - i0, stepm_n - m0);
      end
   endtask

   task automatic test_reset_mid_read();
      txn_t e;
      int   w;
      exp_q.push_back('{1'b0, pa_m, 12'o0000});
      sw[EXAM_I] = 1'b1;
      w = 0;
      while (mem.MEM_REQ !== 1'b1 && w < 40) begin
         tick(1);
         w++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (mem.MEM_REQ !== 1'b1 || mem.MEM_ADDR !== e.addr || mem.MEM_WE !== e.we) begin
         n_bad++;
         $display("FAIL rst_read_req: req=%b addr=%o we=%b, required 1 %o %b", mem.MEM_REQ, mem.MEM_ADDR, mem.MEM_WE, e.addr, e.we);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      n_cmp++;
      if (mem.MEM_REQ !== 1'b0 || BUSY !== 1'b0 || DISP_MA !== '0 || DISP_MB !== '0) begin
         n_bad++;
         $display("FAIL rst_async: req=%b busy=%b ma=%o mb=%o, required 0 0 0000 0000", mem.MEM_REQ, BUSY, DISP_MA, DISP_MB);
      end
      sw[EXAM_I] = 1'b0;
      tick(3);
      RESET_N = 1'b1;
      pa_m = '0;
      tick(2);
      mem_op(EXAM_I, 12'o0000, 1, 12'o1111, 1, "exam_after_rst");
      n_cmp++;
      if (DISP_MB !== 12'o1111 || DISP_MA !== 12'o0001) begin
         n_bad++;
         $display("FAIL exam_after_rst_disp: mb=%o ma=%o, required 1111 0001", DISP_MB, DISP_MA);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_addr();
      test_deposit_wrap();
      test_examine();
      test_timeout();
      test_pulses();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
